// File: rtl/i2c_mon_pkg.sv
// Shared types and constants for the I2C bus monitor: FSM state encoding and
// bit-counter geometry used by the top and the testbench.
package i2c_mon_pkg;

  localparam int unsigned BIT_CNT_W   = 4;
  localparam int unsigned ACK_BIT_IDX = 8;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_BUF  = 2'd2
  } mon_state_e;

endpackage

// File: rtl/i2c_sample_strobe_gen.sv
// Prescaler that produces the single-cycle sample strobe for the SCL/SDA
// edge-detector flops; period is cfg_sample_div + 1 clk cycles.
module i2c_sample_strobe_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_en,
  input  logic [PRESCALE_W-1:0] cfg_sample_div,
  output logic                  edge_flop_en
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic                  strobe_q, strobe_d;

  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves it
    // unassigned; a missing default here would infer a latch.
    cnt_d    = cnt_q + PRESCALE_W'(1);
    strobe_d = 1'b0;
    if (!cfg_en) begin
      cnt_d = '0;
    end else if (cnt_q >= cfg_sample_div) begin
      // >= rather than == so a divisor lowered below the count fires at once.
      cnt_d    = '0;
      strobe_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign edge_flop_en = strobe_q;

endmodule

// File: rtl/i2c_bus_monitor.sv
// I2C bus-state monitor: decodes START/repeated START/STOP from edge pulses,
// tracks busy/free with a post-STOP hold-off, counts bits, captures ACK and
// flags arbitration loss. All outputs are registered.
module i2c_bus_monitor
  import i2c_mon_pkg::*;
#(
  parameter int PRESCALE_W = 16,
  parameter int BUF_W      = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_en,
  input  logic [PRESCALE_W-1:0] cfg_sample_div,
  input  logic [BUF_W-1:0]      cfg_buf_ticks,
  input  logic                  scl_in,
  input  logic                  sda_in,
  input  logic                  scl_rise,
  input  logic                  scl_fall,
  input  logic                  sda_rise,
  input  logic                  sda_fall,
  input  logic                  mst_active,
  input  logic                  mst_sda_oe,
  input  logic                  arb_clr,
  output logic                  edge_flop_en,
  output logic                  start_det,
  output logic                  rstart_det,
  output logic                  stop_det,
  output logic                  bus_busy,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  byte_done,
  output logic                  ack_bit,
  output logic                  arb_lost,
  output logic                  arb_lost_flag
);

  logic strobe;

  i2c_sample_strobe_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_strobe_gen (
    .clk            (clk),
    .resetn         (resetn),
    .cfg_en         (cfg_en),
    .cfg_sample_div (cfg_sample_div),
    .edge_flop_en   (strobe)
  );

  assign edge_flop_en = strobe;

  // An SDA edge coincident with any SCL edge is a data change, not a condition.
  logic scl_edge, start_c, stop_c, arb_c;
  assign scl_edge = scl_rise | scl_fall;
  assign start_c  = sda_fall & scl_in & ~scl_edge;
  assign stop_c   = sda_rise & scl_in & ~scl_edge;
  assign arb_c    = scl_rise & mst_active & ~mst_sda_oe & ~sda_in;

  mon_state_e       state_q, state_d;
  logic [BUF_W-1:0] buf_cnt_q, buf_cnt_d;
  logic [BUF_W-1:0] buf_cnt_inc;
  bit_cnt_t         bit_cnt_q, bit_cnt_d;
  logic             ack_bit_q, ack_bit_d;
  logic             start_det_q, start_det_d;
  logic             rstart_det_q, rstart_det_d;
  logic             stop_det_q, stop_det_d;
  logic             byte_done_q, byte_done_d;
  logic             arb_lost_q, arb_lost_d;
  logic             arb_flag_q, arb_flag_d;
  logic             bus_busy_q, bus_busy_d;

  assign buf_cnt_inc = buf_cnt_q + BUF_W'(1);

  always_comb begin
    state_d      = state_q;
    buf_cnt_d    = buf_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    ack_bit_d    = ack_bit_q;
    start_det_d  = 1'b0;
    rstart_det_d = 1'b0;
    stop_det_d   = 1'b0;
    byte_done_d  = 1'b0;
    arb_lost_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d     = ST_BUSY;
          start_det_d = 1'b1;
          bit_cnt_d   = '0;
        end else if (stop_c) begin
          stop_det_d = 1'b1;
        end
      end

      ST_BUSY: begin
        if (start_c) begin
          rstart_det_d = 1'b1;
          bit_cnt_d    = '0;
        end else if (stop_c) begin
          state_d    = ST_BUF;
          stop_det_d = 1'b1;
          buf_cnt_d  = '0;
          bit_cnt_d  = '0;
        end else if (scl_rise) begin
          if (bit_cnt_q == bit_cnt_t'(ACK_BIT_IDX)) begin
            bit_cnt_d   = '0;
            byte_done_d = 1'b1;
            ack_bit_d   = sda_in;
          end else begin
            bit_cnt_d = bit_cnt_q + bit_cnt_t'(1);
          end
          arb_lost_d = arb_c;
        end
      end

      ST_BUF: begin
        if (start_c) begin
          state_d     = ST_BUSY;
          start_det_d = 1'b1;
          bit_cnt_d   = '0;
        end else if (stop_c) begin
          // A further STOP restarts the hold-off from scratch.
          stop_det_d = 1'b1;
          buf_cnt_d  = '0;
        end else if (cfg_buf_ticks == '0) begin
          state_d   = ST_IDLE;
          buf_cnt_d = '0;
        end else if (strobe) begin
          if (buf_cnt_inc >= cfg_buf_ticks) begin
            state_d   = ST_IDLE;
            buf_cnt_d = '0;
          end else begin
            buf_cnt_d = buf_cnt_inc;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (!cfg_en) begin
      state_d      = ST_IDLE;
      buf_cnt_d    = '0;
      bit_cnt_d    = '0;
      ack_bit_d    = 1'b0;
      start_det_d  = 1'b0;
      rstart_det_d = 1'b0;
      stop_det_d   = 1'b0;
      byte_done_d  = 1'b0;
      arb_lost_d   = 1'b0;
    end

    // Sticky flag survives cfg_en=0; a new loss wins over a coincident clear.
    arb_flag_d = arb_lost_d | (arb_flag_q & ~arb_clr);
    bus_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      buf_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      ack_bit_q    <= 1'b0;
      start_det_q  <= 1'b0;
      rstart_det_q <= 1'b0;
      stop_det_q   <= 1'b0;
      byte_done_q  <= 1'b0;
      arb_lost_q   <= 1'b0;
      arb_flag_q   <= 1'b0;
      bus_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_cnt_q    <= buf_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      ack_bit_q    <= ack_bit_d;
      start_det_q  <= start_det_d;
      rstart_det_q <= rstart_det_d;
      stop_det_q   <= stop_det_d;
      byte_done_q  <= byte_done_d;
      arb_lost_q   <= arb_lost_d;
      arb_flag_q   <= arb_flag_d;
      bus_busy_q   <= bus_busy_d;
    end
  end

  assign start_det     = start_det_q;
  assign rstart_det    = rstart_det_q;
  assign stop_det      = stop_det_q;
  assign bus_busy      = bus_busy_q;
  assign bit_cnt       = bit_cnt_q;
  assign byte_done     = byte_done_q;
  assign ack_bit       = ack_bit_q;
  assign arb_lost      = arb_lost_q;
  assign arb_lost_flag = arb_flag_q;

endmodule

// File: doc/i2c_bus_monitor.md
Name: i2c_bus_monitor

Overview:
- Sequencing and bus-state controller for the SCL/SDA edge-detector pair in the APB I2C master.
- Generates the sample strobe that enables the edge-detector flops.
- Consumes the edge pulses and synchronized line levels to decode START, repeated START and STOP, and to track bus busy/free with a post-STOP hold-off.
- Counts bits per byte, captures the ACK bit and detects arbitration loss for the master FSM and APB status registers.

Parameters:
PRESCALE_W, 16, width of sample-strobe divider
BUF_W, 8, width of post-STOP bus-free hold-off counter

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
cfg_en  in  1  monitor enable
cfg_sample_div  in  PRESCALE_W  strobe period minus one, in clk cycles
cfg_buf_ticks  in  BUF_W  strobes required in BUF state before bus declared free
scl_in  in  1  synchronized SCL level
sda_in  in  1  synchronized SDA level
scl_rise, scl_fall, sda_rise, sda_fall  in  1 each  single-cycle edge pulses from edge detector
mst_active  in  1  local master owns current transfer
mst_sda_oe  in  1  local master driving SDA low (open-drain)
arb_clr  in  1  clears sticky arbitration flag
edge_flop_en  out  1  sample strobe to edge detector
start_det  out  1  pulse, START from IDLE/BUF
rstart_det  out  1  pulse, START while BUSY
stop_det  out  1  pulse, STOP
bus_busy  out  1  level, state != IDLE
bit_cnt  out  4  bits received in current byte, 0..8
byte_done  out  1  pulse on 9th SCL rise
ack_bit  out  1  SDA captured on 9th SCL rise (0 = ACK)
arb_lost  out  1  pulse on arbitration loss
arb_lost_flag  out  1  sticky arbitration-loss flag

Behaviour:
- Reset: every output 0; state IDLE; all counters 0.
- Clocking: single clock domain; reset is asynchronous and active-low. Every output is registered.
- Prescaler:
  - Counter runs 0..cfg_sample_div; edge_flop_en is high for one cycle when count >= cfg_sample_div, then the counter restarts at 0.
  - cfg_sample_div=0 gives a strobe every cycle.
  - Lowering cfg_sample_div below the current count fires the strobe on the next cycle.
- Condition decode, evaluated each cycle an edge pulse is present:
  - START = sda_fall && scl_in && !scl_rise && !scl_fall.
  - STOP = sda_rise && scl_in && !scl_rise && !scl_fall.
  - An SDA edge in the same cycle as any SCL edge is treated as a data change and is not decoded.
- FSM states: IDLE, BUSY, BUF.
  - IDLE --START--> BUSY; start_det pulses.
  - BUSY --START--> BUSY; rstart_det pulses; bit_cnt <= 0.
  - BUSY --STOP--> BUF; stop_det pulses; buf counter <= 0.
  - BUF: buf counter increments on each edge_flop_en. On the strobe that reaches cfg_buf_ticks, go to IDLE. cfg_buf_ticks=0 means BUF lasts exactly one cycle.
  - BUF --START--> BUSY; start_det pulses.
  - STOP in IDLE: stop_det pulses; state unchanged.
- Outputs: all pulses are one cycle wide, registered, and appear one cycle after the causing edge pulse. bus_busy updates in the same cycle.
- Bit counter (BUSY only), on scl_rise:
  - If bit_cnt < 8: bit_cnt increments.
  - If bit_cnt == 8: bit_cnt <= 0, byte_done pulses, ack_bit <= sda_in.
  - START or STOP clears bit_cnt.
- Arbitration (BUSY only): on scl_rise with mst_active=1, mst_sda_oe=0 and sda_in=0:
  - arb_lost pulses and arb_lost_flag sets.
  - arb_clr clears the flag; if set and clear coincide, set wins.
- cfg_en=0: prescaler held at 0, edge_flop_en=0, FSM forced to IDLE, counters and outputs cleared synchronously. arb_lost_flag is retained.
- cfg_en rising: restart from IDLE. The monitor does not infer a transfer already in progress.

Decomposition:
- Package i2c_mon_pkg: state enum (IDLE, BUSY, BUF); constant ACK_BIT_IDX = 8; bit-counter width 4.
- One sub-module, i2c_sample_strobe_gen: holds the prescaler and produces edge_flop_en.
- FSM, bit counter and arbitration logic live in the top module.

Test Plan:
- cfg_sample_div=3, cfg_en=1 -> edge_flop_en high one cycle in every 4, first strobe 4 cycles after enable; cfg_sample_div=0 -> strobe every cycle.
- scl_in=1 with sda_fall pulse -> start_det=1 and bus_busy=1 the next cycle; then sda_rise with scl_in=1 -> stop_det=1; cfg_buf_ticks=5 -> bus_busy drops on the 5th strobe after STOP.
- Byte 0xA5 then ACK=0 over 9 SCL rises -> bit_cnt steps 1..8 then 0; byte_done=1 once; ack_bit=0. A second START mid-byte at bit_cnt=4 -> rstart_det=1, bit_cnt=0, bus_busy stays 1.
- mst_active=1, mst_sda_oe=0, sda_in=0 at scl_rise -> arb_lost pulse and arb_lost_flag=1; arb_clr together with a second loss -> flag stays 1; arb_clr alone -> flag 0.
- sda_fall coincident with scl_fall while scl_in=1 -> no start_det; STOP in IDLE -> stop_det=1, bus_busy stays 0.
- resetn asserted mid-byte in BUSY -> all outputs 0 immediately; cfg_en dropped in BUF -> IDLE next cycle, edge_flop_en=0, arb_lost_flag unchanged.
